// File: rtl/mn_matrix_pkg.sv
// Shared sizing and loader state encoding for the matrix store and its loader.
package mn_matrix_pkg;
  localparam int DATA_W  = 32;
  localparam int MAX_DIM = 128;
  localparam int ADDR_W  = 8;
  localparam int ROW_W   = $clog2(MAX_DIM);
  localparam int IDX_W   = 2 * ROW_W;
  localparam int SHIFT_W = $clog2(DATA_W);
  localparam int FLAT_W  = MAX_DIM * MAX_DIM * DATA_W;

  localparam logic [ADDR_W-1:0] MAX_DIM_A = ADDR_W'(MAX_DIM);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_CONSTRUCT = 1'b1
  } state_t;
endpackage

// File: rtl/mn_matrix_construct.sv
// Loader: streams a row-major packed matrix bus into the store's write port, one entry per cycle.
module matrix_construct
  import mn_matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] m_dim,
  input  logic [ADDR_W-1:0] n_dim,
  input  logic [FLAT_W-1:0] matrix_in,
  output logic              write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] n_addr,
  output logic [DATA_W-1:0] matrix_entry,
  output logic              q_Idle,
  output logic              q_Construct
);
  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_m;
  logic [ADDR_W-1:0]   r_n;
  logic [ADDR_W-1:0]   r_row;
  logic [ADDR_W-1:0]   r_col;
  logic [IDX_W-1:0]    r_idx;
  logic [FLAT_W-1:0]   r_matrix;
  logic                w_start_ok;
  logic                w_col_last;
  logic                w_last;
  logic [IDX_W+SHIFT_W-1:0] w_bit_base;

  assign w_start_ok = start && (m_dim != '0) && (m_dim <= MAX_DIM_A)
                            && (n_dim != '0) && (n_dim <= MAX_DIM_A);
  assign w_col_last = (r_col == r_n - ADDR_W'(1));
  assign w_last     = w_col_last && (r_row == r_m - ADDR_W'(1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_start_ok) w_state_next = S_CONSTRUCT;
      S_CONSTRUCT: if (w_last)     w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_n     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE) begin
        if (w_start_ok) begin
          r_m   <= m_dim;
          r_n   <= n_dim;
          r_row <= '0;
          r_col <= '0;
          r_idx <= '0;
        end
      end else begin
        // r_idx tracks row*n + col without a multiplier
        r_idx <= r_idx + IDX_W'(1);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + ADDR_W'(1);
        end else begin
          r_col <= r_col + ADDR_W'(1);
        end
      end
    end
  end

  // Payload latch carries no reset; it is only meaningful while constructing.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_start_ok) r_matrix <= matrix_in;
  end

  assign w_bit_base   = {r_idx, {SHIFT_W{1'b0}}};
  assign write        = (r_state == S_CONSTRUCT);
  assign m_addr       = r_row;
  assign n_addr       = r_col;
  assign matrix_entry = r_matrix[w_bit_base +: DATA_W];
  assign q_Idle       = (r_state == S_IDLE);
  assign q_Construct  = (r_state == S_CONSTRUCT);
endmodule

// File: rtl/mn_matrix.sv
// Row-major m x n matrix store with single-entry write and normal/transposed registered read.
module mn_matrix
  import mn_matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] m_dim,
  input  logic [ADDR_W-1:0] n_dim,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [ADDR_W-1:0] n_addr,
  input  logic              transpose,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] r_mem [0:MAX_DIM-1][0:MAX_DIM-1];
  logic [DATA_W-1:0] r_data_out;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_rd_row;
  logic [ADDR_W-1:0] w_rd_col;
  logic              w_rd_ok;

  // Extra MAX_DIM bound keeps indices inside the array when dims exceed it.
  assign w_wr_ok = write && (m_addr < m_dim) && (n_addr < n_dim)
                         && (m_addr < MAX_DIM_A) && (n_addr < MAX_DIM_A);

  assign w_rd_row = transpose ? n_addr : m_addr;
  assign w_rd_col = transpose ? m_addr : n_addr;
  assign w_rd_ok  = (w_rd_row < m_dim) && (w_rd_col < n_dim)
                 && (w_rd_row < MAX_DIM_A) && (w_rd_col < MAX_DIM_A);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[m_addr[ROW_W-1:0]][n_addr[ROW_W-1:0]] <= data_in;
  end

  // Same-edge write and read returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (read) begin
      r_data_out <= w_rd_ok ? r_mem[w_rd_row[ROW_W-1:0]][w_rd_col[ROW_W-1:0]] : '0;
    end
  end

  assign data_out = r_data_out;
endmodule

// File: tb/tb_mn_matrix.sv
// Directed bench: loader streams a 3x2 matrix into the store, then normal, transposed and edge-case reads.
module tb_mn_matrix;
  import mn_matrix_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] m_dim, n_dim;
  logic [FLAT_W-1:0] matrix_in;
  logic              ld_write;
  logic [ADDR_W-1:0] ld_m_addr, ld_n_addr;
  logic [DATA_W-1:0] ld_entry;
  logic              q_idle, q_construct;

  logic              tb_write, tb_read, tb_transpose;
  logic [ADDR_W-1:0] tb_m_addr, tb_n_addr;
  logic [DATA_W-1:0] tb_data_in;
  logic              st_write;
  logic [ADDR_W-1:0] st_m_addr, st_n_addr;
  logic [DATA_W-1:0] st_data_in;
  logic [DATA_W-1:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign st_write   = ld_write | tb_write;
  assign st_m_addr  = ld_write ? ld_m_addr : tb_m_addr;
  assign st_n_addr  = ld_write ? ld_n_addr : tb_n_addr;
  assign st_data_in = ld_write ? ld_entry  : tb_data_in;

  matrix_construct u_ld (
    .clk(clk), .reset(reset), .start(start), .m_dim(m_dim), .n_dim(n_dim),
    .matrix_in(matrix_in), .write(ld_write), .m_addr(ld_m_addr), .n_addr(ld_n_addr),
    .matrix_entry(ld_entry), .q_Idle(q_idle), .q_Construct(q_construct)
  );

  mn_matrix u_dut (
    .clk(clk), .reset(reset), .write(st_write), .read(tb_read),
    .m_dim(m_dim), .n_dim(n_dim), .m_addr(st_m_addr), .n_addr(st_n_addr),
    .transpose(tb_transpose), .data_in(st_data_in), .data_out(data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic tr, input int ma, input int na);
    tb_read      = 1'b1;
    tb_transpose = tr;
    tb_m_addr    = ADDR_W'(ma);
    tb_n_addr    = ADDR_W'(na);
    tick();
    tb_read = 1'b0;
  endtask

  int exp_row [6] = '{0, 0, 1, 1, 2, 2};
  int exp_col [6] = '{0, 1, 0, 1, 0, 1};
  int exp_val [6] = '{1, 2, 3, 4, 5, 6};
  int exp_tr  [6] = '{1, 3, 5, 2, 4, 6};

  initial begin
    reset = 1'b1; start = 1'b0; m_dim = '0; n_dim = '0; matrix_in = '0;
    tb_write = 1'b0; tb_read = 1'b0; tb_transpose = 1'b0;
    tb_m_addr = '0; tb_n_addr = '0; tb_data_in = '0;
    for (int k = 0; k < 6; k++) matrix_in[k*DATA_W +: DATA_W] = DATA_W'(k + 1);

    tick();
    check("rst_data_out", data_out, 0);
    check("rst_q_idle", {31'd0, q_idle}, 1);
    check("rst_write", {31'd0, ld_write}, 0);
    reset = 1'b0;
    tick();

    // Load 3x2 through the loader
    m_dim = 8'd3; n_dim = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("ld_write", {31'd0, ld_write}, 1);
      check("ld_q_constr", {31'd0, q_construct}, 1);
      check("ld_m_addr", {24'd0, ld_m_addr}, exp_row[k]);
      check("ld_n_addr", {24'd0, ld_n_addr}, exp_col[k]);
      check("ld_entry", ld_entry, exp_val[k]);
      tick();
    end
    check("ld_done_idle", {31'd0, q_idle}, 1);
    check("ld_done_write", {31'd0, ld_write}, 0);

    // Normal reads, row by row
    for (int k = 0; k < 6; k++) begin
      rd(1'b0, exp_row[k], exp_col[k]);
      check("rd_normal", data_out, exp_val[k]);
    end
    tb_m_addr = 8'd0; tb_n_addr = 8'd0;
    tick();
    check("rd_hold", data_out, 6);

    // Transposed reads over the 2x3 matrix A'
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) begin
        rd(1'b1, i, j);
        check("rd_transpose", data_out, exp_tr[i*3 + j]);
      end

    // Out-of-range write dropped, out-of-range reads return 0
    tb_write = 1'b1; tb_m_addr = 8'd3; tb_n_addr = 8'd0; tb_data_in = 32'd99;
    tick();
    tb_write = 1'b0;
    rd(1'b0, 3, 0);
    check("rd_oor_norm", data_out, 0);
    rd(1'b0, 2, 1);
    check("rd_after_oor", data_out, 6);
    rd(1'b1, 2, 0);
    check("rd_oor_trans", data_out, 0);

    // Same-cycle write and read returns old data
    tb_write = 1'b1; tb_data_in = 32'd7;
    rd(1'b0, 1, 1);
    tb_write = 1'b0;
    check("rw_old", data_out, 4);
    rd(1'b0, 1, 1);
    check("rw_new", data_out, 7);

    // Reset in the middle of a load
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_constr", {31'd0, q_construct}, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_idle", {31'd0, q_idle}, 1);
    check("rst_mid_write", {31'd0, ld_write}, 0);
    check("rst_mid_dout", data_out, 0);
    tick();
    reset = 1'b0;
    tick();

    // Start with illegal dims is ignored
    n_dim = 8'd0; start = 1'b1;
    tick();
    check("zero_dim_idle", {31'd0, q_idle}, 1);
    check("zero_dim_wr", {31'd0, ld_write}, 0);
    n_dim = 8'd2; m_dim = 8'd129;
    tick();
    start = 1'b0;
    check("big_dim_idle", {31'd0, q_idle}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
